// File: rtl/rv_mem_pkg.sv
// rv_mem_pkg: shared definitions for the unified-memory arbiter.
//   MMIO_BIT_DEF : default data byte-address bit that selects the MMIO window
//   LED_W_DEF    : default width of the board LED register
//   owner_t      : identifies which core port owns a grant or a response
package rv_mem_pkg;

  localparam int MMIO_BIT_DEF = 12;
  localparam int LED_W_DEF    = 3;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

endpackage

// File: rtl/rv_rr_arb2.sv
// rv_rr_arb2: two-requester round-robin arbiter with combinational grant.
//   clk   in  clock
//   reset in  synchronous, active-high; forces grants low, last owner = I
//   req   in  [1:0] requests, bit 0 = instruction port, bit 1 = data port
//   gnt   out [1:0] one-hot grant, same cycle as the request
module rv_rr_arb2
  import rv_mem_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  owner_t r_last_gnt;

  always_comb begin
    gnt = 2'b00;
    if (!reset) begin
      if (req == 2'b11) begin
        // Contention: hand the access to whoever did not have it last.
        gnt = (r_last_gnt == OWN_I) ? 2'b10 : 2'b01;
      end else begin
        gnt = req;
      end
    end
  end

  // Idle cycles leave the previous owner in place.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_gnt <= OWN_I;
    end else if (gnt[1]) begin
      r_last_gnt <= OWN_D;
    end else if (gnt[0]) begin
      r_last_gnt <= OWN_I;
    end
  end

endmodule

// File: rtl/rv_mem_arbiter.sv
// rv_mem_arbiter: shares one single-port synchronous RAM between the core's
// instruction-fetch and data ports, and decodes an MMIO window holding the
// board LED register.
//   clk, reset                     clock, synchronous active-high reset
//   i_req/i_addr -> i_gnt          instruction read request and grant
//   i_rvalid/i_rdata               fetch response, 1 cycle after i_gnt
//   d_req/d_we/d_addr/d_wdata/d_be data request (read or byte-masked write)
//   d_gnt, d_rvalid/d_rdata        data grant and response (0 data for writes)
//   m_en/m_we/m_addr/m_wdata       RAM access port, m_rdata returned 1 cycle later
//   leds                           LED register, written via the MMIO window
module rv_mem_arbiter
  import rv_mem_pkg::*;
#(
  parameter int AW       = 10,
  parameter int MMIO_BIT = MMIO_BIT_DEF,
  parameter int LED_W    = LED_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_be,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              m_en,
  output logic [3:0]        m_we,
  output logic [AW-1:0]     m_addr,
  output logic [31:0]       m_wdata,
  input  logic [31:0]       m_rdata,
  output logic [LED_W-1:0]  leds
);

  logic [1:0]       w_gnt;
  logic             w_d_mmio;
  logic             w_i_rvalid;
  logic             w_d_rvalid;
  logic             w_unused;

  logic             r_resp_i;
  logic             r_resp_d;
  logic             r_resp_mmio;
  logic             r_resp_we;
  logic [31:0]      r_mmio_rd;
  logic [LED_W-1:0] r_leds;

  rv_rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   ({d_req, i_req}),
    .gnt   (w_gnt)
  );

  assign i_gnt    = w_gnt[0];
  assign d_gnt    = w_gnt[1];
  assign w_d_mmio = d_addr[MMIO_BIT];

  // Address bits outside the word index (and the byte offset) are ignored.
  assign w_unused = ^{i_addr[31:AW+2], i_addr[1:0], d_addr[31:AW+2], d_addr[1:0]};

  // Request stage: drive the RAM in the grant cycle.
  always_comb begin
    m_en    = 1'b0;
    m_we    = 4'b0000;
    m_addr  = '0;
    m_wdata = '0;
    if (w_gnt[0]) begin
      m_en   = 1'b1;
      m_addr = i_addr[AW+1:2];
    end else if (w_gnt[1] && !w_d_mmio) begin
      m_en    = 1'b1;
      m_addr  = d_addr[AW+1:2];
      m_we    = d_we ? d_be : 4'b0000;
      m_wdata = d_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_resp_i    <= 1'b0;
      r_resp_d    <= 1'b0;
      r_resp_mmio <= 1'b0;
      r_resp_we   <= 1'b0;
      r_leds      <= '0;
    end else begin
      r_resp_i <= w_gnt[0];
      r_resp_d <= w_gnt[1];
      if (w_gnt[1]) begin
        r_resp_mmio <= w_d_mmio;
        r_resp_we   <= d_we;
        if (w_d_mmio && d_we) begin
          r_leds <= d_wdata[LED_W-1:0];
        end
      end
    end
  end

  // MMIO read captures the LED value as it stood at the grant edge.
  always_ff @(posedge clk) begin
    if (w_gnt[1] && w_d_mmio && !d_we) begin
      r_mmio_rd <= {{(32-LED_W){1'b0}}, r_leds};
    end
  end

  // Response stage: a response landing while reset is high is dropped.
  assign w_i_rvalid = r_resp_i & ~reset;
  assign w_d_rvalid = r_resp_d & ~reset;

  assign i_rvalid = w_i_rvalid;
  assign d_rvalid = w_d_rvalid;
  assign i_rdata  = w_i_rvalid ? m_rdata : 32'h0;
  assign d_rdata  = (w_d_rvalid && !r_resp_we) ? (r_resp_mmio ? r_mmio_rd : m_rdata) : 32'h0;
  assign leds     = r_leds;

endmodule

// File: tb/tb_rv_mem_arbiter.sv
module tb_rv_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        m_en;
  logic [3:0]  m_we;
  logic [9:0]  m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic [2:0]  leds;

  int checks = 0;
  int errors = 0;

  logic        pl_en;
  logic [9:0]  pl_addr;
  logic [31:0] pl_data;
  logic [31:0] mem [0:1023];

  rv_mem_arbiter dut (
    .clk      (clk),
    .reset    (reset),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_gnt    (i_gnt),
    .i_rvalid (i_rvalid),
    .i_rdata  (i_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_be     (d_be),
    .d_gnt    (d_gnt),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .m_en     (m_en),
    .m_we     (m_we),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_rdata  (m_rdata),
    .leds     (leds)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port synchronous RAM with byte strobes; a preload port for the bench.
  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else if (m_en) begin
      m_rdata <= mem[m_addr];
      for (int b = 0; b < 4; b++) begin
        if (m_we[b]) mem[m_addr][b*8 +: 8] <= m_wdata[b*8 +: 8];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [9:0] a, input logic [31:0] d);
    pl_en   = 1'b1;
    pl_addr = a;
    pl_data = d;
    tick();
    pl_en   = 1'b0;
  endtask

  initial begin
    logic [31:0] seq_exp [0:3];
    seq_exp[0] = 32'h1000_0001;
    seq_exp[1] = 32'h2000_0002;
    seq_exp[2] = 32'h3000_0003;
    seq_exp[3] = 32'h4000_0004;

    reset = 1'b1; i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0; m_rdata = '0;

    preload(10'd0,  seq_exp[0]);
    preload(10'd1,  seq_exp[1]);
    preload(10'd2,  seq_exp[2]);
    preload(10'd3,  seq_exp[3]);
    preload(10'd5,  32'h0000_0013);
    preload(10'd16, 32'h1111_1111);

    // Reset state with both requests asserted: nothing granted.
    i_req = 1'b1; d_req = 1'b1; i_addr = 32'h14; d_addr = 32'h0; d_we = 1'b0;
    #1;
    chk("rst_i_gnt",    {31'b0, i_gnt},    32'h0);
    chk("rst_d_gnt",    {31'b0, d_gnt},    32'h0);
    chk("rst_m_en",     {31'b0, m_en},     32'h0);
    chk("rst_i_rvalid", {31'b0, i_rvalid}, 32'h0);
    chk("rst_d_rvalid", {31'b0, d_rvalid}, 32'h0);
    chk("rst_leds",     {29'b0, leds},     32'h0);
    tick();

    // Contention right after reset: D, I, D, I.
    reset = 1'b0;
    #1;
    chk("con1_d_gnt", {31'b0, d_gnt}, 32'h1);
    chk("con1_i_gnt", {31'b0, i_gnt}, 32'h0);
    chk("con1_m_addr", {22'b0, m_addr}, 32'h0);
    tick();
    chk("con2_i_gnt", {31'b0, i_gnt}, 32'h1);
    chk("con2_d_gnt", {31'b0, d_gnt}, 32'h0);
    chk("con2_m_addr", {22'b0, m_addr}, 32'h5);
    chk("con2_d_rvalid", {31'b0, d_rvalid}, 32'h1);
    chk("con2_d_rdata", d_rdata, 32'h1000_0001);
    chk("con2_i_rvalid", {31'b0, i_rvalid}, 32'h0);
    tick();
    chk("con3_d_gnt", {31'b0, d_gnt}, 32'h1);
    chk("con3_i_rvalid", {31'b0, i_rvalid}, 32'h1);
    chk("con3_i_rdata", i_rdata, 32'h0000_0013);
    chk("con3_d_rvalid", {31'b0, d_rvalid}, 32'h0);
    tick();
    chk("con4_i_gnt", {31'b0, i_gnt}, 32'h1);
    chk("con4_d_rvalid", {31'b0, d_rvalid}, 32'h1);
    chk("con4_d_rdata", d_rdata, 32'h1000_0001);
    tick();
    i_req = 1'b0; d_req = 1'b0;
    #1;
    chk("con5_i_rvalid", {31'b0, i_rvalid}, 32'h1);
    chk("con5_i_rdata", i_rdata, 32'h0000_0013);
    chk("con5_m_en", {31'b0, m_en}, 32'h0);
    tick();
    chk("idle_i_rvalid", {31'b0, i_rvalid}, 32'h0);
    chk("idle_i_rdata", i_rdata, 32'h0);

    // Lone fetch; upper address bits ignored (0xFFFFF014 -> word 5).
    i_req = 1'b1; i_addr = 32'hFFFF_F014;
    #1;
    chk("fetch_i_gnt", {31'b0, i_gnt}, 32'h1);
    chk("fetch_m_en", {31'b0, m_en}, 32'h1);
    chk("fetch_m_we", {28'b0, m_we}, 32'h0);
    chk("fetch_m_addr", {22'b0, m_addr}, 32'h5);
    tick();
    i_req = 1'b0;
    #1;
    chk("fetch_i_rvalid", {31'b0, i_rvalid}, 32'h1);
    chk("fetch_i_rdata", i_rdata, 32'h0000_0013);
    chk("fetch_d_rvalid", {31'b0, d_rvalid}, 32'h0);

    // Byte-masked write then read back.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hCAFE_BABE; d_be = 4'b0011;
    #1;
    chk("wr_d_gnt", {31'b0, d_gnt}, 32'h1);
    chk("wr_m_we", {28'b0, m_we}, 32'h3);
    chk("wr_m_addr", {22'b0, m_addr}, 32'h10);
    chk("wr_m_wdata", m_wdata, 32'hCAFE_BABE);
    tick();
    d_we = 1'b0; d_be = 4'b0000;
    #1;
    chk("wr_d_rvalid", {31'b0, d_rvalid}, 32'h1);
    chk("wr_d_rdata", d_rdata, 32'h0);
    chk("rd_d_gnt", {31'b0, d_gnt}, 32'h1);
    chk("rd_m_we", {28'b0, m_we}, 32'h0);
    tick();
    d_req = 1'b0;
    #1;
    chk("rd_d_rvalid", {31'b0, d_rvalid}, 32'h1);
    chk("rd_d_rdata", d_rdata, 32'h1111_BABE);

    // Back-to-back reads at 0x0, 0x4, 0x8, 0xC.
    d_req = 1'b1; d_we = 1'b0;
    for (int k = 0; k < 4; k++) begin
      d_addr = 32'(k * 4);
      #1;
      chk("b2b_d_gnt", {31'b0, d_gnt}, 32'h1);
      chk("b2b_m_addr", {22'b0, m_addr}, 32'(k));
      tick();
      chk("b2b_d_rvalid", {31'b0, d_rvalid}, 32'h1);
      chk("b2b_d_rdata", d_rdata, seq_exp[k]);
    end
    d_req = 1'b0;
    tick();
    chk("b2b_end_rvalid", {31'b0, d_rvalid}, 32'h0);

    // MMIO write then read of the LED register.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1000; d_wdata = 32'h0000_0005; d_be = 4'b0000;
    #1;
    chk("mmw_d_gnt", {31'b0, d_gnt}, 32'h1);
    chk("mmw_m_en", {31'b0, m_en}, 32'h0);
    chk("mmw_leds_pre", {29'b0, leds}, 32'h0);
    tick();
    d_we = 1'b0;
    #1;
    chk("mmw_leds", {29'b0, leds}, 32'h5);
    chk("mmw_d_rvalid", {31'b0, d_rvalid}, 32'h1);
    chk("mmw_d_rdata", d_rdata, 32'h0);
    chk("mmr_m_en", {31'b0, m_en}, 32'h0);
    tick();
    d_req = 1'b0;
    #1;
    chk("mmr_d_rvalid", {31'b0, d_rvalid}, 32'h1);
    chk("mmr_d_rdata", d_rdata, 32'h0000_0005);

    // Reset asserted in the cycle after a fetch grant.
    i_req = 1'b1; i_addr = 32'h14;
    #1;
    chk("rmid_i_gnt", {31'b0, i_gnt}, 32'h1);
    tick();
    reset = 1'b1;
    #1;
    chk("rmid_i_rvalid", {31'b0, i_rvalid}, 32'h0);
    chk("rmid_i_rdata", i_rdata, 32'h0);
    chk("rmid_i_gnt_rst", {31'b0, i_gnt}, 32'h0);
    chk("rmid_m_en", {31'b0, m_en}, 32'h0);
    tick();
    chk("rmid_leds", {29'b0, leds}, 32'h0);
    chk("rmid_i_rvalid2", {31'b0, i_rvalid}, 32'h0);
    reset = 1'b0;
    #1;
    chk("rpost_i_gnt", {31'b0, i_gnt}, 32'h1);
    chk("rpost_m_addr", {22'b0, m_addr}, 32'h5);
    tick();
    i_req = 1'b0;
    #1;
    chk("rpost_i_rvalid", {31'b0, i_rvalid}, 32'h1);
    chk("rpost_i_rdata", i_rdata, 32'h0000_0013);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv_mem_arbiter.md
Name: rv_mem_arbiter

Overview:
- Shares one single-port synchronous RAM between the core's instruction-fetch port and data port.
- Decodes a small MMIO window for the board LED register.
- Per-port request/grant/rvalid handshake; one RAM access per cycle; 2-way round-robin arbitration.
- Sits between rv_core and the unified memory in the top-level wrapper, replacing the separate instruction and data memories.

Parameters:
- AW, 10, RAM word-address width (RAM depth 2**AW words of 32 bits).
- MMIO_BIT, 12, data byte-address bit that selects the MMIO window when 1.
- LED_W, 3, width of the LED register.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- i_req  in  1  instruction read request; held with i_addr until granted
- i_addr  in  32  instruction byte address; bits [AW+1:2] used
- i_gnt  out  1  request accepted this cycle
- i_rvalid  out  1  i_rdata valid, exactly 1 cycle after i_gnt
- i_rdata  out  32  fetched word
- d_req  in  1  data request; held with d_we/d_addr/d_wdata/d_be until granted
- d_we  in  1  1 = write, 0 = read
- d_addr  in  32  data byte address
- d_wdata  in  32  write data
- d_be  in  4  byte enables for writes
- d_gnt  out  1  request accepted this cycle
- d_rvalid  out  1  read data or write ack valid, 1 cycle after d_gnt
- d_rdata  out  32  read data; 0 for writes
- m_en  out  1  RAM access enable
- m_we  out  4  RAM byte write strobes
- m_addr  out  AW  RAM word address
- m_wdata  out  32  RAM write data
- m_rdata  in  32  RAM read data, valid 1 cycle after m_en
- leds  out  LED_W  LED register

Behaviour:
- Reset clears i_rvalid, d_rvalid, leds and the response-tracking registers, and sets last_gnt = I.
  - Data therefore wins the first conflict.
  - While reset is high, i_gnt, d_gnt and m_en are 0 (combinationally gated).
- Arbitration (combinational, same cycle as req):
  - Only one requester: it is granted.
  - Both requesting: grant the port not granted last (last_gnt).
  - last_gnt updates only on a grant; an idle cycle preserves it.
- Grant to I:
  - m_en=1, m_we=0, m_addr=i_addr[AW+1:2].
- Grant to D, RAM space (d_addr[MMIO_BIT]=0):
  - m_en=1, m_addr=d_addr[AW+1:2].
  - m_we = d_we ? d_be : 4'b0; m_wdata=d_wdata.
- Grant to D, MMIO space (d_addr[MMIO_BIT]=1):
  - m_en=0.
  - Write: leds <= d_wdata[LED_W-1:0] at this clock edge. d_be is ignored.
  - Read: the response returns zero-extended leds as sampled at the grant edge.
- Response pipeline (registered):
  - resp_i, resp_d, resp_mmio and the mmio read value are registered on grant.
  - Next cycle:
    - i_rvalid=resp_i, i_rdata=m_rdata.
    - d_rvalid=resp_d, d_rdata = write ? 0 : (resp_mmio ? mmio value : m_rdata).
  - i_rdata and d_rdata are 0 when the matching rvalid=0.
- Throughput:
  - A new grant may occur in the same cycle a response is delivered, giving 1 access per cycle when back-to-back.
  - Under contention each port gets 1 access per 2 cycles.
- No ungranted request is dropped. A port whose request is not granted keeps it pending with no state change.
- Address bits above AW+1, other than MMIO_BIT for data, are ignored. Addresses wrap in RAM.
- Misalignment: low two address bits ignored; no exception.
- Reset mid-transaction: a response due in the cycle after reset asserts is suppressed (rvalid=0). A RAM write issued in the cycle before reset still completes.

Decomposition:
- Package rv_mem_pkg:
  - localparams MMIO_BIT_DEF=12 and LED_W_DEF=3.
  - Enum owner_t {OWN_I, OWN_D} for last_gnt and the response owner.
- One sub-module rv_rr_arb2:
  - 2-requester round-robin arbiter.
  - Inputs: clk, reset, req[1:0].
  - Outputs: one-hot gnt[1:0].
  - Contains the last_gnt register.

Test Plan:
- Lone fetch: RAM[5]=0x00000013; i_req with i_addr=0x14 -> i_gnt same cycle, m_addr=5, i_rvalid next cycle with i_rdata=0x00000013, d_rvalid=0.
- Data write then read: d_we=1, d_addr=0x40, d_wdata=0xCAFEBABE, d_be=4'b0011 over prior 0x11111111 -> readback 0x1111BABE; the write response has d_rdata=0.
- Contention: i_req and d_req both held for 4 cycles after reset -> grants D, I, D, I; each rvalid 1 cycle after its grant; no lost request.
- Back-to-back: d_req alone for 4 consecutive reads at 0x0, 0x4, 0x8, 0xC -> d_gnt every cycle; d_rvalid on 4 consecutive cycles with matching data.
- MMIO: write 0x5 to 0x1000 -> leds=3'b101 after the edge, m_en=0; read 0x1000 -> d_rdata=0x00000005.
- Reset mid-op: reset asserted in the cycle after i_gnt -> i_rvalid=0 and leds=0; a pending i_req is first granted in the first cycle after reset deasserts.
